// File: rtl/ocm_multiport.sv
// ocm_multiport: shared on-chip memory for N_CORES cores.
// A round-robin arbiter hands out ownership on request. Ownership is held
// until the owner pulses i_done or drops i_req. While it holds ownership,
// the owner can issue reads, byte-masked writes and single-word atomics
// (AMOSWAP / AMOADD). A separate read-only port serves debug inspection.
//
// Handshake: o_ready[k] is high only for the owner while the state is OWNED.
// An access from core k is accepted on a clock edge where i_valid[k] and
// o_ready[k] are both high. No other cycle accepts an access, and inputs
// from cores that do not own the bus are ignored.
module ocm_multiport #(
    parameter int N_CORES   = 2,
    parameter int ADDR_BITS = 12
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [N_CORES-1:0]            i_req,
    input  logic [N_CORES-1:0]            i_done,
    output logic [N_CORES-1:0]            o_grant,
    input  logic [N_CORES-1:0]            i_valid,
    output logic [N_CORES-1:0]            o_ready,
    input  logic [2*N_CORES-1:0]          i_op,
    input  logic [N_CORES*ADDR_BITS-1:0]  i_addr,
    input  logic [32*N_CORES-1:0]         i_wdata,
    input  logic [4*N_CORES-1:0]          i_be,
    output logic [32*N_CORES-1:0]         o_rdata,
    output logic [N_CORES-1:0]            o_rvalid,
    input  logic [ADDR_BITS-1:0]          addr_tb,
    output logic [31:0]                   out_tb,
    output logic [1:0]                    dbg_state
);

    localparam int IW    = $clog2(N_CORES);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWNED  = 2'd1,
        AMO_WB = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  own, own_nxt;
    logic [IW-1:0]  last, last_nxt;
    logic [IW-1:0]  sel;

    logic [31:0]    mem [DEPTH];

    // Per-core views of the packed request buses
    logic [1:0]            op_a    [N_CORES];
    logic [ADDR_BITS-1:0]  addr_a  [N_CORES];
    logic [31:0]           wdata_a [N_CORES];
    logic [3:0]            be_a    [N_CORES];
    logic [31:0]           rdata_q [N_CORES];
    logic [N_CORES-1:0]    rvalid_q;

    for (genvar g = 0; g < N_CORES; g++) begin : g_unpack
        assign op_a[g]    = i_op[2*g +: 2];
        assign addr_a[g]  = i_addr[g*ADDR_BITS +: ADDR_BITS];
        assign wdata_a[g] = i_wdata[32*g +: 32];
        assign be_a[g]    = i_be[4*g +: 4];
        assign o_rdata[32*g +: 32] = rdata_q[g];
    end

    assign o_rvalid  = rvalid_q;
    assign dbg_state = state;

    // Fields of the current owner's request
    logic                  own_valid, own_done, own_req;
    logic [1:0]            own_op;
    logic [ADDR_BITS-1:0]  own_addr;
    logic [31:0]           own_wdata;
    logic [3:0]            own_be;

    assign own_valid = i_valid[own];
    assign own_done  = i_done[own];
    assign own_req   = i_req[own];
    assign own_op    = op_a[own];
    assign own_addr  = addr_a[own];
    assign own_wdata = wdata_a[own];
    assign own_be    = be_a[own];

    // Operands captured when an atomic is issued, used for the write-back
    logic [ADDR_BITS-1:0]  amo_addr;
    logic [31:0]           amo_operand;
    logic [31:0]           amo_old;
    logic                  amo_add;

    logic acc_read, acc_write, acc_amo;

    // Round-robin pick: first requester after the last owner, with wrap
    function automatic logic [IW-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                              input logic [IW-1:0] prev);
        logic [IW-1:0] pick;
        logic [IW-1:0] ci;
        logic          found;
        int            c;
        pick  = prev;
        found = 1'b0;
        for (int i = 1; i <= N_CORES; i++) begin
            c  = (int'(prev) + i) % N_CORES;
            ci = IW'(c);
            if (!found && req[ci]) begin
                found = 1'b1;
                pick  = ci;
            end
        end
        return pick;
    endfunction

    assign sel = rr_pick(i_req, last);

    // Next-state logic and access decode for the owner
    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        last_nxt  = last;
        acc_read  = 1'b0;
        acc_write = 1'b0;
        acc_amo   = 1'b0;
        case (state)
            IDLE: begin
                if (|i_req) begin
                    own_nxt   = sel;
                    state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (own_valid) begin
                    case (own_op)
                        2'b00:   acc_read  = 1'b1;
                        2'b01:   acc_write = 1'b1;
                        default: acc_amo   = 1'b1;
                    endcase
                end
                // An atomic must finish its write-back before release is honoured
                if (acc_amo) begin
                    state_nxt = AMO_WB;
                end else if (own_done || !own_req) begin
                    last_nxt  = own;
                    state_nxt = IDLE;
                end
            end
            AMO_WB: begin
                state_nxt = OWNED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-derived grant and ready
    always_comb begin
        o_grant = '0;
        o_ready = '0;
        if (state != IDLE) o_grant[own] = 1'b1;
        if (state == OWNED) o_ready[own] = 1'b1;
    end

    // Single memory write port shared by owner writes and atomic write-back
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wbe;

    // Write-port mux; reset suppresses any pending write-back
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = own_addr;
        mem_wdata = own_wdata;
        mem_wbe   = own_be;
        if (state == AMO_WB) begin
            mem_we    = 1'b1;
            mem_waddr = amo_addr;
            mem_wdata = amo_add ? (amo_old + amo_operand) : amo_operand;
            mem_wbe   = 4'hF;
        end else if (acc_write) begin
            mem_we = 1'b1;
        end
        if (!nrst) mem_we = 1'b0;
    end

    // Byte-lane memory write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Debug read port; returns pre-write data on a same-cycle collision
    always_ff @(posedge clk) begin
        out_tb <= mem[addr_tb];
    end

    // Arbiter state, owner tracking and registered read data
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            own      <= '0;
            last     <= IW'(N_CORES - 1);
            rvalid_q <= '0;
            for (int k = 0; k < N_CORES; k++) rdata_q[k] <= '0;
        end else begin
            state    <= state_nxt;
            own      <= own_nxt;
            last     <= last_nxt;
            rvalid_q <= '0;
            if (acc_read || acc_amo) begin
                rdata_q[own]  <= mem[own_addr];
                rvalid_q[own] <= 1'b1;
            end
        end
    end

    // Atomic operand capture at issue
    always_ff @(posedge clk) begin
        if (acc_amo) begin
            amo_addr    <= own_addr;
            amo_operand <= own_wdata;
            amo_old     <= mem[own_addr];
            amo_add     <= own_op[0];
        end
    end

endmodule

// File: tb/tb_ocm_multiport.sv
// Testbench for ocm_multiport with four cores and a 64-word memory.
// A transaction-level model of ownership, memory contents and per-core
// read results predicts the outputs. One compare process checks them on
// every falling edge. Directed sequences add literal expectations, and a
// randomized phase follows them.
module tb_ocm_multiport;

    localparam int N  = 4;
    localparam int AB = 6;
    localparam int DEPTH = 1 << AB;

    logic               clk;
    logic               nrst;
    logic [N-1:0]       req, done, valid;
    logic [2*N-1:0]     op;
    logic [N*AB-1:0]    addr;
    logic [32*N-1:0]    wdata;
    logic [4*N-1:0]     be;
    logic [AB-1:0]      addr_tb;
    logic [N-1:0]       o_grant, o_ready, o_rvalid;
    logic [32*N-1:0]    o_rdata;
    logic [31:0]        out_tb;
    logic [1:0]         dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    ocm_multiport #(.N_CORES(N), .ADDR_BITS(AB)) dut (
        .clk(clk), .nrst(nrst),
        .i_req(req), .i_done(done), .o_grant(o_grant),
        .i_valid(valid), .o_ready(o_ready),
        .i_op(op), .i_addr(addr), .i_wdata(wdata), .i_be(be),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid),
        .addr_tb(addr_tb), .out_tb(out_tb), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner = -1;      // -1: nobody owns the bus
    int          m_last  = N - 1;
    bit          m_amo   = 1'b0;    // owner is in the atomic write-back cycle
    bit [1:0]    m_amo_op;
    int          m_amo_addr;
    logic [31:0] m_amo_opnd, m_amo_old;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_rdata [N];
    logic [N-1:0] m_rvalid = '0;
    logic [31:0] m_out_tb;
    bit          m_out_known = 1'b0;
    bit          m_started = 1'b0;

    initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // Advance the model by one clock using the sampled inputs
    always @(posedge clk) begin
        int k, a;
        logic [1:0]  o;
        logic [31:0] d;
        logic [3:0]  b;
        m_out_known = m_known[addr_tb];
        m_out_tb    = m_mem[addr_tb];
        if (!nrst) begin
            m_started = 1'b1;
            m_owner   = -1;
            m_amo     = 1'b0;
            m_last    = N - 1;
            m_rvalid  = '0;
            for (int i = 0; i < N; i++) m_rdata[i] = '0;
        end else begin
            m_rvalid = '0;
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    if (m_owner < 0 && req[(m_last + i) % N]) m_owner = (m_last + i) % N;
                end
            end else if (m_amo) begin
                m_mem[m_amo_addr] = (m_amo_op == 2'b10) ? m_amo_opnd : m_amo_old + m_amo_opnd;
                m_amo = 1'b0;
            end else begin
                k = m_owner;
                if (valid[k]) begin
                    o = op[2*k +: 2];
                    a = int'(addr[AB*k +: AB]);
                    d = wdata[32*k +: 32];
                    b = be[4*k +: 4];
                    if (o == 2'b00) begin
                        m_rdata[k]  = m_mem[a];
                        m_rvalid[k] = 1'b1;
                    end else if (o == 2'b01) begin
                        for (int j = 0; j < 4; j++) if (b[j]) m_mem[a][8*j +: 8] = d[8*j +: 8];
                        if (b == 4'hF) m_known[a] = 1'b1;
                    end else begin
                        m_rdata[k]  = m_mem[a];
                        m_rvalid[k] = 1'b1;
                        m_amo       = 1'b1;
                        m_amo_op    = o;
                        m_amo_addr  = a;
                        m_amo_opnd  = d;
                        m_amo_old   = m_mem[a];
                    end
                end
                if (!m_amo && (done[k] || !req[k])) begin
                    m_last  = k;
                    m_owner = -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] eg, er;
        if (m_started) begin
            eg = '0;
            er = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                if (!m_amo) er[m_owner] = 1'b1;
            end
            check("grant", 32'(o_grant), 32'(eg));
            check("ready", 32'(o_ready), 32'(er));
            check("rvalid", 32'(o_rvalid), 32'(m_rvalid));
            for (int k = 0; k < N; k++)
                check($sformatf("rdata%0d", k), o_rdata[32*k +: 32], m_rdata[k]);
            if (m_out_known) check("out_tb", out_tb, m_out_tb);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic acquire(input int k);
        req[k] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (o_grant[k]) break;
        end
        check($sformatf("acquire%0d", k), 32'(o_grant), 32'(1) << k);
    endtask

    task automatic access(input int k, input logic [1:0] o, input int a,
                          input logic [31:0] d, input logic [3:0] b);
        valid[k]           = 1'b1;
        op[2*k +: 2]       = o;
        addr[AB*k +: AB]   = AB'(a);
        wdata[32*k +: 32]  = d;
        be[4*k +: 4]       = b;
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nrst = 1'b0; req = '0; done = '0; valid = '0;
        op = '0; addr = '0; wdata = '0; be = '0; addr_tb = '0;
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(o_grant), 32'h0);
        check("reset_rdata1", o_rdata[63:32], 32'h0);
        nrst = 1'b1;

        // Simultaneous request: core 0 wins first, core 1 after one dead cycle
        req[0] = 1'b1; req[1] = 1'b1;
        @(negedge clk);
        check("grant_first", 32'(o_grant), 32'h1);
        check("ready_first", 32'(o_ready), 32'h1);
        done[0] = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        done[0] = 1'b0;
        check("handover_gap", 32'(o_grant), 32'h0);
        @(negedge clk);
        check("handover_next", 32'(o_grant), 32'h2);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Fill memory so every word has a known value
        acquire(0);
        for (int a = 0; a < DEPTH; a++) access(0, 2'b01, a, $urandom, 4'hF);
        access(0, 2'b01, 'h30, 32'hCAFEF00D, 4'hF);

        // Byte-enable merge then read-back
        access(0, 2'b01, 'h10, 32'hDEADBEEF, 4'hF);
        access(0, 2'b01, 'h10, 32'h0000AA00, 4'b0010);
        access(0, 2'b00, 'h10, 32'h0, 4'h0);
        check("be_merge", o_rdata[31:0], 32'hDEADAAEF);
        check("be_rvalid", 32'(o_rvalid), 32'h1);

        // AMOADD with wraparound, AMOSWAP
        access(0, 2'b01, 'h20, 32'd5, 4'hF);
        access(0, 2'b11, 'h20, 32'hFFFFFFFE, 4'h0);
        check("amoadd_old", o_rdata[31:0], 32'd5);
        check("amo_ready_low", 32'(o_ready), 32'h0);
        @(negedge clk);
        check("amo_ready_back", 32'(o_ready), 32'h1);
        access(0, 2'b00, 'h20, 32'h0, 4'h0);
        check("amoadd_new", o_rdata[31:0], 32'd3);
        access(0, 2'b01, 'h24, 32'd0, 4'hF);
        access(0, 2'b10, 'h24, 32'd1, 4'h0);
        check("amoswap_old", o_rdata[31:0], 32'd0);
        @(negedge clk);
        access(0, 2'b00, 'h24, 32'h0, 4'h0);
        check("amoswap_new", o_rdata[31:0], 32'd1);

        // Non-owner traffic is ignored
        valid[1] = 1'b1; op[3:2] = 2'b01; addr[2*AB-1:AB] = AB'('h10);
        wdata[63:32] = 32'hFFFFFFFF; be[7:4] = 4'hF; done[1] = 1'b1;
        @(negedge clk);
        valid[1] = 1'b0; done[1] = 1'b0;
        check("nonowner_rvalid", 32'(o_rvalid[1]), 32'h0);
        access(0, 2'b00, 'h10, 32'h0, 4'h0);
        check("nonowner_nowrite", o_rdata[31:0], 32'hDEADAAEF);
        check("owner_kept", 32'(o_grant), 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        check("drop_req_release", 32'(o_grant), 32'h0);
        @(negedge clk);

        // Reset during the atomic write-back cycle
        acquire(2);
        access(2, 2'b10, 'h30, 32'h12345678, 4'h0);
        check("amo_before_reset", o_rdata[95:64], 32'hCAFEF00D);
        nrst = 1'b0; req = '0;
        @(negedge clk);
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_ready", 32'(o_ready), 32'h0);
        check("rst_rvalid", 32'(o_rvalid), 32'h0);
        check("rst_rdata2", o_rdata[95:64], 32'h0);
        nrst = 1'b1;

        // All cores requesting: rotation 0,1,2,3,0 with one idle cycle each
        req = '1;
        for (int s = 0; s < 5; s++) begin
            int e;
            e = s % N;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (o_grant != '0) break;
            end
            check($sformatf("rot_grant%0d", s), 32'(o_grant), 32'(1) << e);
            access(e, 2'b00, 'h30, 32'h0, 4'h0);
            check($sformatf("rot_nowb%0d", s), o_rdata[32*e +: 32], 32'hCAFEF00D);
            done[e] = 1'b1;
            @(negedge clk);
            done[e] = 1'b0;
            check($sformatf("rot_gap%0d", s), 32'(o_grant), 32'h0);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Randomized traffic from all cores, with occasional reset
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
                done[k]  = ($urandom_range(0, 9) == 0);
                valid[k] = ($urandom_range(0, 1) == 1);
            end
            op      = 2*N'($urandom);
            addr    = (N*AB)'({$urandom, $urandom});
            wdata   = {$urandom, $urandom, $urandom, $urandom};
            be      = 4*N'($urandom);
            addr_tb = AB'($urandom);
            nrst    = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        nrst = 1'b1; req = '0; done = '0; valid = '0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
